// File: rtl/csi2tx_p2b_dw_fifo_pkg.sv
// Shared widths, FIFO entry layout and byte-count normalisation for the p2b data-word FIFO.
package csi2tx_p2b_dw_fifo_pkg;

  localparam int DW_W    = 32;
  localparam int NB_W    = 3;
  localparam int ENTRY_W = 35;
  localparam int WC_W    = 16;
  localparam int ACC_W   = 17;

  typedef struct packed {
    logic             last;
    logic [1:0]       nbm1;
    logic [DW_W-1:0]  dat;
  } entry_t;

  // 0 and anything above 4 are treated as a full word.
  function automatic logic [NB_W-1:0] norm_nbytes(input logic [NB_W-1:0] nb);
    if (nb == 3'd0 || nb > 3'd4) begin
      return 3'd4;
    end
    return nb;
  endfunction

endpackage

// File: rtl/csi2tx_p2b_wc_acc.sv
// Per-line byte accumulator producing the long-packet word count with 16-bit saturation.
// wc/wc_vld are registered one cycle after the accepted line-end word.
module csi2tx_p2b_wc_acc
  import csi2tx_p2b_dw_fifo_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            acc_en,
  input  logic            drop_last,
  input  logic [NB_W-1:0] nbytes,
  input  logic            last,
  output logic [WC_W-1:0] wc,
  output logic            wc_vld
);

  localparam logic [ACC_W-1:0] ACC_SAT = 17'h10000;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic             wc_vld_q, wc_vld_d;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc_q} + {{(ACC_W+1-NB_W){1'b0}}, nbytes};

  always_comb begin
    acc_d    = acc_q;
    wc_d     = wc_q;
    wc_vld_d = 1'b0;
    if (acc_en) begin
      if (last) begin
        wc_d     = (sum > 18'h0FFFF) ? 16'hFFFF : sum[WC_W-1:0];
        wc_vld_d = 1'b1;
        acc_d    = '0;
      end else begin
        // Pin the running count once it is past 16 bits; the line is already saturated.
        acc_d = (sum > {1'b0, ACC_SAT}) ? ACC_SAT : sum[ACC_W-1:0];
      end
    end else if (drop_last) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      wc_q     <= '0;
      wc_vld_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      wc_q     <= wc_d;
      wc_vld_q <= wc_vld_d;
    end
  end

  assign wc     = wc_q;
  assign wc_vld = wc_vld_q;

endmodule

// File: rtl/csi2tx_p2b_dw_fifo.sv
// Show-ahead FIFO for p2b data words with line word-count generation; level/high-water ports
// exist only when CSI2TX_P2B_FIFO_LVL_EN is defined. Write-to-valid latency 1; full FIFO drops and flags.
module csi2tx_p2b_dw_fifo
  import csi2tx_p2b_dw_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW_W-1:0] dw,
  input  logic            dw_vld,
  input  logic [NB_W-1:0] dw_nbytes,
  input  logic            dw_last,
  input  logic            clr,
  output logic [DW_W-1:0] fifo_dout,
  output logic [NB_W-1:0] fifo_nbytes,
  output logic            fifo_last,
  output logic            fifo_vld,
  input  logic            fifo_rdy,
  output logic [WC_W-1:0] wc,
  output logic            wc_vld,
  output logic            ovf_sticky
`ifdef CSI2TX_P2B_FIFO_LVL_EN
  ,
  output logic [AW:0]     fifo_lvl,
  output logic [AW:0]     fifo_hwm
`endif
);

  entry_t          mem_q [DEPTH];
  entry_t          head;
  entry_t          wr_entry;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            empty, full, pop, push, drop;
  logic [NB_W-1:0] nb_norm;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && fifo_rdy;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a word.
  assign push  = dw_vld && (!full || pop);
  assign drop  = dw_vld && !push;

  assign nb_norm       = norm_nbytes(dw_nbytes);
  assign wr_entry.last = dw_last;
  assign wr_entry.nbm1 = nb_norm[1:0] - 2'd1;
  assign wr_entry.dat  = dw;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (drop)     ovf_d = 1'b1;
    else if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
    end
  end

  // Outputs are forced to zero while empty so stale storage never leaks out.
  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign fifo_vld    = !empty;
  assign fifo_dout   = empty ? '0 : head.dat;
  assign fifo_nbytes = empty ? '0 : ({1'b0, head.nbm1} + 3'd1);
  assign fifo_last   = empty ? 1'b0 : head.last;
  assign ovf_sticky  = ovf_q;

  csi2tx_p2b_wc_acc u_wc_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_en    (push),
    .drop_last (drop && dw_last),
    .nbytes    (nb_norm),
    .last      (dw_last),
    .wc        (wc),
    .wc_vld    (wc_vld)
  );

`ifdef CSI2TX_P2B_FIFO_LVL_EN
  logic [AW:0] lvl_q, lvl_d;
  logic [AW:0] hwm_q, hwm_d;

  always_comb begin
    lvl_d = wr_ptr_d - rd_ptr_d;
    hwm_d = hwm_q;
    if (clr)                hwm_d = '0;
    else if (lvl_d > hwm_q) hwm_d = lvl_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q <= '0;
      hwm_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      hwm_q <= hwm_d;
    end
  end

  assign fifo_lvl = lvl_q;
  assign fifo_hwm = hwm_q;
`endif

endmodule

// File: tb/tb_csi2tx_p2b_dw_fifo.sv
// Directed bench for csi2tx_p2b_dw_fifo: vector table plus hand-written overflow/saturation/reset sequences.
module tb_csi2tx_p2b_dw_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dw;
  logic        dw_vld;
  logic [2:0]  dw_nbytes;
  logic        dw_last;
  logic        clr;
  logic [31:0] fifo_dout;
  logic [2:0]  fifo_nbytes;
  logic        fifo_last;
  logic        fifo_vld;
  logic        fifo_rdy;
  logic [15:0] wc;
  logic        wc_vld;
  logic        ovf_sticky;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  csi2tx_p2b_dw_fifo dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dw          (dw),
    .dw_vld      (dw_vld),
    .dw_nbytes   (dw_nbytes),
    .dw_last     (dw_last),
    .clr         (clr),
    .fifo_dout   (fifo_dout),
    .fifo_nbytes (fifo_nbytes),
    .fifo_last   (fifo_last),
    .fifo_vld    (fifo_vld),
    .fifo_rdy    (fifo_rdy),
    .wc          (wc),
    .wc_vld      (wc_vld),
    .ovf_sticky  (ovf_sticky)
  );

  typedef struct {
    logic        vld;
    logic [31:0] d;
    logic [2:0]  nb;
    logic        last;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_dout;
    logic [2:0]  e_nb;
    logic        e_last;
    logic        e_wcv;
    logic [15:0] e_wc;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] nb,
                       input logic l, input logic r);
    dw_vld = v; dw = d; dw_nbytes = nb; dw_last = l; fifo_rdy = r;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [2:0] nb,
                              input logic l, input logic r, input logic ev,
                              input logic [31:0] ed, input logic [2:0] en, input logic el,
                              input logic ewv, input logic [15:0] ew);
    vec_t t;
    t.vld = v; t.d = d; t.nb = nb; t.last = l; t.rdy = r;
    t.e_vld = ev; t.e_dout = ed; t.e_nb = en; t.e_last = el; t.e_wcv = ewv; t.e_wc = ew;
    return t;
  endfunction

  initial begin
    vec_t v;
    logic [31:0] expq[$];
    logic [31:0] e;
    int pops;
    int wcv_cnt;

    rst_n = 1'b0; clr = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);

    // Line 1: four full words; line 2: nbytes 7 and 0 normalise to 4, last word carries 3.
    vecs[0] = mk(1, 32'hA0A0_0001, 4, 0, 1,  1, 32'hA0A0_0001, 4, 0, 0, 16'd0);
    vecs[1] = mk(1, 32'hA0A0_0002, 4, 0, 1,  1, 32'hA0A0_0002, 4, 0, 0, 16'd0);
    vecs[2] = mk(1, 32'hA0A0_0003, 4, 0, 1,  1, 32'hA0A0_0003, 4, 0, 0, 16'd0);
    vecs[3] = mk(1, 32'hA0A0_0004, 4, 1, 1,  1, 32'hA0A0_0004, 4, 1, 1, 16'd16);
    vecs[4] = mk(0, 32'h0,         0, 0, 1,  0, 32'h0,         0, 0, 0, 16'd16);
    vecs[5] = mk(1, 32'hB0B0_0001, 7, 0, 1,  1, 32'hB0B0_0001, 4, 0, 0, 16'd16);
    vecs[6] = mk(1, 32'hB0B0_0002, 4, 0, 1,  1, 32'hB0B0_0002, 4, 0, 0, 16'd16);
    vecs[7] = mk(1, 32'hB0B0_0003, 0, 0, 1,  1, 32'hB0B0_0003, 4, 0, 0, 16'd16);
    vecs[8] = mk(1, 32'hB0B0_0004, 3, 1, 1,  1, 32'hB0B0_0004, 3, 1, 1, 16'd15);
    vecs[9] = mk(0, 32'h0,         0, 0, 1,  0, 32'h0,         0, 0, 0, 16'd15);

    step(); step();
    chk("rst_fifo_vld", 32'(fifo_vld), 32'd0);
    chk("rst_fifo_dout", fifo_dout, 32'd0);
    chk("rst_fifo_nbytes", 32'(fifo_nbytes), 32'd0);
    chk("rst_fifo_last", 32'(fifo_last), 32'd0);
    chk("rst_wc", 32'(wc), 32'd0);
    chk("rst_wc_vld", 32'(wc_vld), 32'd0);
    chk("rst_ovf", 32'(ovf_sticky), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      drive(v.vld, v.d, v.nb, v.last, v.rdy);
      step();
      chk($sformatf("v%0d_vld", i), 32'(fifo_vld), 32'(v.e_vld));
      chk($sformatf("v%0d_dout", i), fifo_dout, v.e_dout);
      chk($sformatf("v%0d_nb", i), 32'(fifo_nbytes), 32'(v.e_nb));
      chk($sformatf("v%0d_last", i), 32'(fifo_last), 32'(v.e_last));
      chk($sformatf("v%0d_wcv", i), 32'(wc_vld), 32'(v.e_wcv));
      chk($sformatf("v%0d_wc", i), 32'(wc), 32'(v.e_wc));
    end

    // Fill with no consumer, 17th push is dropped.
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'h3000 + i, 4, 0, 0);
      step();
      if (i == 15) begin
        chk("fill16_vld", 32'(fifo_vld), 32'd1);
        chk("fill16_ovf", 32'(ovf_sticky), 32'd0);
      end
    end
    chk("ovf_set", 32'(ovf_sticky), 32'd1);
    chk("ovf_head", fifo_dout, 32'h3000);
    drive(0, 0, 0, 0, 0); clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf_sticky), 32'd0);

    // Push and pop together at full: no drop, line ends 16*4+4 = 68 bytes (dropped word excluded).
    drive(1, 32'h4000, 4, 1, 1);
    step();
    chk("full_pp_ovf", 32'(ovf_sticky), 32'd0);
    chk("full_pp_head", fifo_dout, 32'h3001);
    chk("full_pp_wcv", 32'(wc_vld), 32'd1);
    chk("full_pp_wc", 32'(wc), 32'd68);
    for (int i = 1; i < 16; i++) expq.push_back(32'h3000 + i);
    expq.push_back(32'h4000);
    drive(0, 0, 0, 0, 1);
    pops = 0;
    for (int k = 0; k < 40 && fifo_vld; k++) begin
      e = (expq.size() > 0) ? expq.pop_front() : 32'hDEAD_BEEF;
      chk($sformatf("drain%0d", pops), fifo_dout, e);
      if (pops == 15) chk("drain_last_flag", 32'(fifo_last), 32'd1);
      pops++;
      step();
    end
    chk("drain_count", 32'(pops), 32'd16);

    // 16400 x 4 bytes = 65600 saturates.
    wcv_cnt = 0;
    for (int i = 0; i < 16400; i++) begin
      drive(1, 32'(i), 4, (i == 16399), 1);
      step();
      if (wc_vld) wcv_cnt++;
    end
    chk("sat_wc", 32'(wc), 32'h0000_FFFF);
    chk("sat_wcv_pulses", 32'(wcv_cnt), 32'd1);
    drive(0, 0, 0, 0, 1);
    step();
    chk("sat_wcv_clear", 32'(wc_vld), 32'd0);
    chk("sat_empty", 32'(fifo_vld), 32'd0);

    // Reset with a partial line buffered.
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h5000 + i, 4, 0, 0);
      step();
    end
    chk("pre_rst_head", fifo_dout, 32'h5000);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_vld", 32'(fifo_vld), 32'd0);
    chk("mid_rst_wcv", 32'(wc_vld), 32'd0);
    chk("mid_rst_dout", fifo_dout, 32'd0);
    drive(1, 32'h6000, 2, 0, 1);
    step();
    drive(1, 32'h6001, 2, 1, 1);
    step();
    chk("post_rst_wcv", 32'(wc_vld), 32'd1);
    chk("post_rst_wc", 32'(wc), 32'd4);
    chk("post_rst_head", fifo_dout, 32'h6001);
    drive(0, 0, 0, 0, 1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
